reg_f_arb: RTL and testbench

REG_F_ARB -- requirements
Module: reg_f_arb

---
 rtl/reg_f_arb_if.sv | 41 ++++
 rtl/reg_f_arb.sv | 141 ++++++++++++++
 tb/tb_reg_f_arb.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_f_arb_if.sv
// Bundle between two requesters, the shared reg_f and the arbiter.
// Clock and reset are plain ports on the arbiter; the arbiter uses the slave modport.
interface reg_f_arb_if #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 8
);
    localparam int SW = $clog2(SIZE);

    logic             CLR;
    logic             REQ0;
    logic             REQ1;
    logic             WR0;
    logic             WR1;
    logic [SW-1:0]    SEL0;
    logic [SW-1:0]    SEL1;
    logic [WIDTH-1:0] DIN0;
    logic [WIDTH-1:0] DIN1;
    logic             GNT0;
    logic             GNT1;
    logic             DVALID0;
    logic             DVALID1;
    logic [WIDTH-1:0] DOUT;
    logic             BUSY;
    logic             RF_EN;
    logic             RF_WR;
    logic [SW-1:0]    RF_SEL;
    logic [WIDTH-1:0] RF_IN;
    logic [WIDTH-1:0] RF_OUT;

    modport master (
        output CLR, REQ0, REQ1, WR0, WR1, SEL0, SEL1, DIN0, DIN1, RF_OUT,
        input  GNT0, GNT1, DVALID0, DVALID1, DOUT, BUSY,
               RF_EN, RF_WR, RF_SEL, RF_IN
    );

    modport slave (
        input  CLR, REQ0, REQ1, WR0, WR1, SEL0, SEL1, DIN0, DIN1, RF_OUT,
        output GNT0, GNT1, DVALID0, DVALID1, DOUT, BUSY,
               RF_EN, RF_WR, RF_SEL, RF_IN
    );
endinterface

// File: rtl/reg_f_arb.sv
// Two-requester round-robin arbiter in front of a shared register file,
// with a CLR-triggered sweep that zeroes every register. All outputs are registered.
module reg_f_arb #(
    parameter int WIDTH = 4,
    parameter int SIZE  = 8
) (
    input  logic        CLK,
    input  logic        RST,
    reg_f_arb_if.slave  bus
);
    localparam int SW = $clog2(SIZE);
    localparam logic [SW-1:0] LAST_IDX = SW'(SIZE - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             dvalid0_q, dvalid0_d;
    logic             dvalid1_q, dvalid1_d;
    logic             busy_q, busy_d;
    logic             rf_en_q, rf_en_d;
    logic             rf_wr_q, rf_wr_d;
    logic [SW-1:0]    rf_sel_q, rf_sel_d;
    logic [WIDTH-1:0] rf_in_q, rf_in_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic el0, el1, win0, win1, rd_now;

    // A requester granted this cycle sits out the next arbitration.
    assign el0    = bus.REQ0 & ~gnt0_q;
    assign el1    = bus.REQ1 & ~gnt1_q;
    assign win0   = el0 & (~el1 | last_q);
    assign win1   = el1 & (~el0 | ~last_q);
    assign rd_now = (gnt0_q | gnt1_q) & ~rf_wr_q;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        busy_d    = busy_q;
        rf_en_d   = 1'b0;
        rf_wr_d   = 1'b0;
        rf_sel_d  = rf_sel_q;
        rf_in_d   = rf_in_q;
        // Read capture is independent of the FSM so a grant issued just before CLR still completes.
        dvalid0_d = gnt0_q & ~rf_wr_q;
        dvalid1_d = gnt1_q & ~rf_wr_q;
        dout_d    = rd_now ? bus.RF_OUT : dout_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.CLR) begin
                    state_d  = CLEAR;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    rf_en_d  = 1'b1;
                    rf_wr_d  = 1'b1;
                    rf_sel_d = '0;
                    rf_in_d  = '0;
                end else if (win0) begin
                    gnt0_d   = 1'b1;
                    rf_en_d  = 1'b1;
                    rf_wr_d  = bus.WR0;
                    rf_sel_d = bus.SEL0;
                    rf_in_d  = bus.DIN0;
                    last_d   = 1'b0;
                end else if (win1) begin
                    gnt1_d   = 1'b1;
                    rf_en_d  = 1'b1;
                    rf_wr_d  = bus.WR1;
                    rf_sel_d = bus.SEL1;
                    rf_in_d  = bus.DIN1;
                    last_d   = 1'b1;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    busy_d   = 1'b1;
                    rf_en_d  = 1'b1;
                    rf_wr_d  = 1'b1;
                    rf_sel_d = cnt_q + 1'b1;
                    rf_in_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            dvalid0_q <= 1'b0;
            dvalid1_q <= 1'b0;
            busy_q    <= 1'b0;
            rf_en_q   <= 1'b0;
            rf_wr_q   <= 1'b0;
            rf_sel_q  <= '0;
            rf_in_q   <= '0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            dvalid0_q <= dvalid0_d;
            dvalid1_q <= dvalid1_d;
            busy_q    <= busy_d;
            rf_en_q   <= rf_en_d;
            rf_wr_q   <= rf_wr_d;
            rf_sel_q  <= rf_sel_d;
            rf_in_q   <= rf_in_d;
            dout_q    <= dout_d;
        end
    end

    assign bus.GNT0    = gnt0_q;
    assign bus.GNT1    = gnt1_q;
    assign bus.DVALID0 = dvalid0_q;
    assign bus.DVALID1 = dvalid1_q;
    assign bus.DOUT    = dout_q;
    assign bus.BUSY    = busy_q;
    assign bus.RF_EN   = rf_en_q;
    assign bus.RF_WR   = rf_wr_q;
    assign bus.RF_SEL  = rf_sel_q;
    assign bus.RF_IN   = rf_in_q;
endmodule

// File: tb/tb_reg_f_arb.sv
// Directed bench for reg_f_arb: a behavioural reg_f sits on the RF_* side;
// inputs are driven and outputs sampled on the falling clock edge.
module tb_reg_f_arb;
    localparam int WIDTH = 4;
    localparam int SIZE  = 8;
    localparam int SW    = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [WIDTH-1:0] mem [SIZE];

    reg_f_arb_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

    reg_f_arb #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Register file model: combinational read, write commits at the rising edge.
    always @(posedge CLK) if (bus.RF_EN && bus.RF_WR) mem[bus.RF_SEL] <= bus.RF_IN;
    assign bus.RF_OUT = bus.RF_EN ? mem[bus.RF_SEL] : '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt0"},    32'(bus.GNT0),    0);
        chk({tag, "_gnt1"},    32'(bus.GNT1),    0);
        chk({tag, "_dvalid0"}, 32'(bus.DVALID0), 0);
        chk({tag, "_dvalid1"}, 32'(bus.DVALID1), 0);
        chk({tag, "_busy"},    32'(bus.BUSY),    0);
        chk({tag, "_rf_en"},   32'(bus.RF_EN),   0);
        chk({tag, "_rf_wr"},   32'(bus.RF_WR),   0);
        chk({tag, "_rf_sel"},  32'(bus.RF_SEL),  0);
        chk({tag, "_rf_in"},   32'(bus.RF_IN),   0);
        chk({tag, "_dout"},    32'(bus.DOUT),    0);
    endtask

    // Single write by requester 0; starts and ends on a falling edge with GNT0 low.
    task automatic wr(input logic [SW-1:0] s, input logic [WIDTH-1:0] d);
        bus.REQ0 = 1'b1; bus.WR0 = 1'b1; bus.SEL0 = s; bus.DIN0 = d;
        @(negedge CLK);
        chk("wr_gnt0",   32'(bus.GNT0),   1);
        chk("wr_rf_en",  32'(bus.RF_EN),  1);
        chk("wr_rf_wr",  32'(bus.RF_WR),  1);
        chk("wr_rf_sel", 32'(bus.RF_SEL), 32'(s));
        chk("wr_rf_in",  32'(bus.RF_IN),  32'(d));
        bus.REQ0 = 1'b0;
        @(negedge CLK);
        chk("wr_no_dvalid", 32'(bus.DVALID0), 0);
    endtask

    // Single read by requester 0; ends on the falling edge of the DVALID cycle.
    task automatic rd(input logic [SW-1:0] s, input logic [WIDTH-1:0] e);
        bus.REQ0 = 1'b1; bus.WR0 = 1'b0; bus.SEL0 = s;
        @(negedge CLK);
        chk("rd_gnt0",   32'(bus.GNT0),   1);
        chk("rd_rf_wr",  32'(bus.RF_WR),  0);
        chk("rd_rf_sel", 32'(bus.RF_SEL), 32'(s));
        bus.REQ0 = 1'b0;
        @(negedge CLK);
        chk("rd_dvalid0", 32'(bus.DVALID0), 1);
        chk("rd_dout",    32'(bus.DOUT),    32'(e));
        chk("rd_gnt0_lo", 32'(bus.GNT0),    0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.CLR = 1'b0;
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        bus.WR0 = 1'b0;  bus.WR1 = 1'b0;
        bus.SEL0 = '0;   bus.SEL1 = '0;
        bus.DIN0 = '0;   bus.DIN1 = '0;

        @(negedge CLK);
        @(negedge CLK);
        check_zero("reset");

        // Write then read with the very first cycle out of reset arbitrating.
        RST = 1'b0;
        wr(3'd3, 4'hA);
        rd(3'd3, 4'hA);

        for (int i = 0; i < SIZE; i++) wr(SW'(i), WIDTH'(i + 1));

        // Contention from reset: reg3 holds 4, reg6 holds 7.
        RST = 1'b1;
        bus.REQ0 = 1'b1; bus.REQ1 = 1'b1;
        bus.WR0 = 1'b0;  bus.WR1 = 1'b0;
        bus.SEL0 = 3'd3; bus.SEL1 = 3'd6;
        @(negedge CLK);
        RST = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            chk("cont_gnt0",    32'(bus.GNT0),    32'(k % 2 == 1));
            chk("cont_gnt1",    32'(bus.GNT1),    32'(k % 2 == 0));
            chk("cont_excl",    32'(bus.GNT0 & bus.GNT1), 0);
            chk("cont_dvalid0", 32'(bus.DVALID0), 32'(k >= 2 && k % 2 == 0));
            chk("cont_dvalid1", 32'(bus.DVALID1), 32'(k >= 3 && k % 2 == 1));
            if (k >= 2) chk("cont_dout", 32'(bus.DOUT), (k % 2 == 0) ? 4 : 7);
        end
        bus.REQ0 = 1'b0; bus.REQ1 = 1'b0;
        @(negedge CLK);
        chk("cont_tail_dvalid1", 32'(bus.DVALID1), 1);
        chk("cont_tail_dout",    32'(bus.DOUT),    7);
        chk("cont_tail_gnt",     32'({bus.GNT0, bus.GNT1}), 0);

        // Idle hold after a read of register 5.
        rd(3'd5, 4'd6);
        @(negedge CLK);
        chk("idle_rf_en",   32'(bus.RF_EN),   0);
        chk("idle_rf_wr",   32'(bus.RF_WR),   0);
        chk("idle_rf_sel",  32'(bus.RF_SEL),  5);
        chk("idle_dout",    32'(bus.DOUT),    6);
        chk("idle_dvalid0", 32'(bus.DVALID0), 0);

        // Clear pass with requester 1 waiting on register 2.
        chk("clr_busy_pre", 32'(bus.BUSY), 0);
        bus.CLR = 1'b1; bus.REQ1 = 1'b1; bus.WR1 = 1'b0; bus.SEL1 = 3'd2;
        for (int k = 0; k < SIZE; k++) begin
            @(negedge CLK);
            bus.CLR = 1'b0;
            chk("clr_busy",   32'(bus.BUSY),   1);
            chk("clr_rf_en",  32'(bus.RF_EN),  1);
            chk("clr_rf_wr",  32'(bus.RF_WR),  1);
            chk("clr_rf_sel", 32'(bus.RF_SEL), 32'(k));
            chk("clr_rf_in",  32'(bus.RF_IN),  0);
            chk("clr_gnt1",   32'(bus.GNT1),   0);
        end
        @(negedge CLK);
        chk("clr_end_busy",  32'(bus.BUSY),  0);
        chk("clr_end_gnt1",  32'(bus.GNT1),  0);
        chk("clr_end_rf_en", 32'(bus.RF_EN), 0);
        @(negedge CLK);
        chk("clr_post_gnt1",   32'(bus.GNT1),   1);
        chk("clr_post_rf_sel", 32'(bus.RF_SEL), 2);
        bus.REQ1 = 1'b0;
        @(negedge CLK);
        chk("clr_post_dvalid1", 32'(bus.DVALID1), 1);
        chk("clr_post_dout",    32'(bus.DOUT),    0);
        for (int i = 0; i < SIZE; i++) rd(SW'(i), 4'd0);

        // Reset in the third clear cycle leaves registers 2..7 intact.
        for (int i = 0; i < SIZE; i++) wr(SW'(i), WIDTH'(i + 1));
        rd(3'd7, 4'd8);
        bus.CLR = 1'b1;
        @(negedge CLK);
        bus.CLR = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("midclr_rf_sel", 32'(bus.RF_SEL), 2);
        RST = 1'b1;
        #1;
        check_zero("midclr_rst");
        @(negedge CLK);
        RST = 1'b0;
        rd(3'd0, 4'd0);
        rd(3'd1, 4'd0);
        for (int i = 2; i < SIZE; i++) rd(SW'(i), WIDTH'(i + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
